dram_cmd_sequencer: RTL and testbench
=====================================

Name: dram_cmd_sequencer

Overview:
- Initiator on the row-open tracker interface.
- Accepts one memory request or refresh request at a time.
- Drives the tracker's lookup inputs and sequences PRE/ACT/RD/WR/PREA/REF commands with tRP/tRCD/tCL/tRFC spacing from the returned row status.
- Pulses row_resolve so the tracker updates its open-row table.
- Sits between the controller request queue and the DRAM command bus.

Parameters:
- T_RP, 4, cycles from PRE/PREA to next command (≥2)
- T_RCD, 4, cycles from ACT to RD/WR (≥2)
- T_CL, 4, cycles from RD/WR to resolve (≥2)
- T_RFC, 16, cycles from REF to ref_ack (≥2)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle
- req_write  in  1  1=WR, 0=RD
- req_bg  in  2  bank group
- req_bank  in  2  bank
- req_row  in  ROW_BITS  row
- req_col  in  COL_BITS  column
- ref_req  in  1  refresh requested (level)
- ref_ack  out  1  refresh complete pulse
- done  out  1  request complete pulse
- ro_req_en  out  1  tracker lookup enable
- ro_refresh  out  1  tracker refresh indication
- ro_row_resolve  out  1  tracker update strobe
- ro_bank_group  out  2  latched bank group
- ro_bank  out  2  latched bank
- ro_row  out  ROW_BITS  latched row
- ro_row_stat  in  2  00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT
- ro_row_conflict  in  ROW_BITS  currently open row on conflict
- ro_all_row_closed  in  1  no banks open
- cmd_valid  out  1  command strobe
- cmd  out  3  cmd_t
- cmd_bg  out  2  command bank group
- cmd_bank  out  2  command bank
- cmd_row  out  ROW_BITS  command row
- cmd_col  out  COL_BITS  command column

Behaviour:
- Reset (async, nRST low): FSM=IDLE, counter=0; every output 0; cmd=NOP.
- IDLE:
  - ref_req has priority: go REF_CHK, req_ready=0.
  - Else req_ready=req_valid. On accept, latch bg/bank/row/col/write, go LOOKUP.
- LOOKUP: assert ro_req_en. ro_req_en and the ro_* address hold constant from LOOKUP through RESOLVE inclusive.
- DECIDE: sample ro_row_stat.
  - 01 → RW.
  - 10 → ACT.
  - 11 → PRE.
  - 00 → stay in DECIDE, no timeout.
- PRE: cmd_valid=1, cmd=PRE, cmd_row=ro_row_conflict (captured). Then WAIT_RP, then ACT.
- ACT: cmd=ACT, cmd_row=latched row. Then WAIT_RCD, then RW.
- RW: cmd=RD or WR, cmd_col=latched col. Then WAIT_CL, then RESOLVE.
- RESOLVE: ro_row_resolve=1 and done=1 for exactly one cycle, then IDLE.
- Timing rule: the next command (or RESOLVE) occurs exactly T_x cycles after the issuing command cycle. Wait counters load T_x-1 and decrement to 0.
- Refresh path: ro_refresh held high REF_CHK..REF_WAIT inclusive.
  - REF_CHK: ro_all_row_closed=1 → REF_ISSUE, else REF_PREA.
  - REF_PREA: cmd=PREA, then wait T_RP, then REF_ISSUE.
  - REF_ISSUE: cmd=REF, then wait T_RFC.
  - Then ref_ack=1 for one cycle, ro_refresh drops, IDLE.
- A ref_req arriving mid-request is held off until IDLE. A pending request waits behind a refresh.
- cmd_valid is high only in command-issue states, one cycle each. cmd=NOP otherwise.
- Hit latency (T_CL=4): accept at cycle 0, RD at 3, done at 7.
- Reset mid-sequence aborts immediately. No resolve is emitted.

Optional Feature:
- Macro CMD_PERF_CNT_EN.
- Defined: adds outputs hit_cnt, miss_cnt, conflict_cnt (16 bits each, saturating at 0xFFFF, reset 0). Each increments once per DECIDE exit on the respective status.
- Undefined: ports and logic absent.

Decomposition:
- dram_pkg (existing; extend):
  - ROW_BITS
  - COL_BITS=10
  - cmd_t: NOP, ACT, PRE, PREA, RD, WR, REF
  - seq_state_t
  - row_stat encodings: ROW_IDLE, ROW_HIT, ROW_MISS, ROW_CONFLICT
  - default timing constants
- Sub-module: dram_timing_cnt (load value, decrement, zero flag). Instantiate one, shared across all waits.

Test Plan:
- Hit read: row_stat=01, req row 0x1A, col 0x040 → RD on cycle 3; done and row_resolve on cycle 7; no ACT/PRE.
- Miss write: row_stat=10 → ACT at 3, WR at 7, done at 11.
- Conflict: row_stat=11, row_conflict=0x05, req row 0x09 → PRE row 0x05 at 3, ACT row 0x09 at 7, RD at 11, done at 15.
- Refresh with all_row_closed=0 → PREA, REF 4 cycles later, ref_ack 16 cycles after REF; ro_refresh high throughout. Repeat with all_row_closed=1 → no PREA.
- ref_req and req_valid asserted together in IDLE → refresh completes first, req_ready stays 0 until after ref_ack; then the request proceeds.
- nRST low during WAIT_RCD → all outputs 0 immediately; after release, a new request is accepted normally with no stray resolve.

Source files
------------

// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the DRAM command sequencer.
// Provides row/column widths, the DRAM command encoding (cmd_t), the
// sequencer FSM states (seq_state_t), the tracker row-status encodings,
// the default timing constants, and a helper that maps a sequencer state
// to the command it drives on the bus.
package dram_pkg;

    localparam int ROW_BITS  = 16;
    localparam int COL_BITS  = 10;
    localparam int CNT_W     = 8;

    localparam int T_RP_DEF  = 4;
    localparam int T_RCD_DEF = 4;
    localparam int T_CL_DEF  = 4;
    localparam int T_RFC_DEF = 16;

    localparam logic [1:0] ROW_IDLE     = 2'b00;
    localparam logic [1:0] ROW_HIT      = 2'b01;
    localparam logic [1:0] ROW_MISS     = 2'b10;
    localparam logic [1:0] ROW_CONFLICT = 2'b11;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_PRE  = 3'd2,
        CMD_PREA = 3'd3,
        CMD_RD   = 3'd4,
        CMD_WR   = 3'd5,
        CMD_REF  = 3'd6
    } cmd_t;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_LOOKUP      = 4'd1,
        S_DECIDE      = 4'd2,
        S_PRE         = 4'd3,
        S_WAIT_RP     = 4'd4,
        S_ACT         = 4'd5,
        S_WAIT_RCD    = 4'd6,
        S_RW          = 4'd7,
        S_WAIT_CL     = 4'd8,
        S_RESOLVE     = 4'd9,
        S_REF_CHK     = 4'd10,
        S_REF_PREA    = 4'd11,
        S_REF_WAIT_RP = 4'd12,
        S_REF_ISSUE   = 4'd13,
        S_REF_WAIT    = 4'd14,
        S_REF_DONE    = 4'd15
    } seq_state_t;

    // Command issued while sitting in a given state; NOP outside issue states.
    function automatic cmd_t state_cmd(input seq_state_t s, input logic wr);
        cmd_t c;
        case (s)
            S_PRE:       c = CMD_PRE;
            S_ACT:       c = CMD_ACT;
            S_RW:        c = wr ? CMD_WR : CMD_RD;
            S_REF_PREA:  c = CMD_PREA;
            S_REF_ISSUE: c = CMD_REF;
            default:     c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dram_cmd_sequencer_timing_cnt.sv
// dram_timing_cnt: shared down-counter for the sequencer's wait states.
// Ports: CLK/nRST clock and async active-low reset; load/load_val reload
// the count; expire is high on the cycle the count steps from 1 to 0, so
// a wait state that exits on it lands exactly load_val+1 cycles after the
// cycle that loaded it.
module dram_timing_cnt
    import dram_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on request, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer: takes one memory or refresh request at a time, looks
// the bank up in the row-open tracker, and sequences PRE/ACT/RD/WR or
// PREA/REF on the DRAM command bus with tRP/tRCD/tCL/tRFC spacing.
// Ports: req_* request handshake and address; ref_req/ref_ack refresh
// handshake; done completion pulse; ro_* tracker lookup/update interface;
// cmd_* registered DRAM command bus.
// Optional: define CMD_PERF_CNT_EN to add saturating hit/miss/conflict
// counters (hit_cnt, miss_cnt, conflict_cnt).
module dram_cmd_sequencer
    import dram_pkg::*;
#(
    parameter int T_RP  = T_RP_DEF,
    parameter int T_RCD = T_RCD_DEF,
    parameter int T_CL  = T_CL_DEF,
    parameter int T_RFC = T_RFC_DEF
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_bg,
    input  logic [1:0]          req_bank,
    input  logic [ROW_BITS-1:0] req_row,
    input  logic [COL_BITS-1:0] req_col,
    input  logic                ref_req,
    output logic                ref_ack,
    output logic                done,
    output logic                ro_req_en,
    output logic                ro_refresh,
    output logic                ro_row_resolve,
    output logic [1:0]          ro_bank_group,
    output logic [1:0]          ro_bank,
    output logic [ROW_BITS-1:0] ro_row,
    input  logic [1:0]          ro_row_stat,
    input  logic [ROW_BITS-1:0] ro_row_conflict,
    input  logic                ro_all_row_closed,
    output logic                cmd_valid,
    output cmd_t                cmd,
    output logic [1:0]          cmd_bg,
    output logic [1:0]          cmd_bank,
    output logic [ROW_BITS-1:0] cmd_row,
    output logic [COL_BITS-1:0] cmd_col
`ifdef CMD_PERF_CNT_EN
    ,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt,
    output logic [15:0]         conflict_cnt
`endif
);

    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_CL  = CNT_W'(T_CL - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);

    seq_state_t          state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          bg_q, bg_d, bank_q, bank_d;
    logic [ROW_BITS-1:0] row_q, row_d, conf_q, conf_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic                cnt_load_s;
    logic [CNT_W-1:0]    cnt_val_s;
    logic                cnt_expire_s;

    // Output flops, decoded from the next state so they line up with it.
    logic                cmd_valid_q, cmd_valid_d;
    cmd_t                cmd_q, cmd_d;
    logic [1:0]          cmd_bg_q, cmd_bg_d, cmd_bank_q, cmd_bank_d;
    logic [ROW_BITS-1:0] cmd_row_q, cmd_row_d;
    logic [COL_BITS-1:0] cmd_col_q, cmd_col_d;
    logic                ro_req_en_q, ro_req_en_d;
    logic                ro_refresh_q, ro_refresh_d;
    logic                resolve_q, resolve_d;
    logic                ref_ack_q, ref_ack_d;

    dram_timing_cnt #(.W(CNT_W)) u_cnt (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .expire   (cnt_expire_s)
    );

    // Next-state logic, request capture and wait-counter loads.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        bg_d       = bg_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        conf_d     = conf_q;
        req_ready  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        case (state_q)
            S_IDLE: begin
                // Refresh wins over a waiting request.
                if (ref_req) begin
                    state_d = S_REF_CHK;
                end else if (req_valid) begin
                    req_ready = 1'b1;
                    wr_d      = req_write;
                    bg_d      = req_bg;
                    bank_d    = req_bank;
                    row_d     = req_row;
                    col_d     = req_col;
                    state_d   = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: state_d = S_DECIDE;
            S_DECIDE: begin
                case (ro_row_stat)
                    ROW_HIT:  state_d = S_RW;
                    ROW_MISS: state_d = S_ACT;
                    ROW_CONFLICT: begin
                        state_d = S_PRE;
                        conf_d  = ro_row_conflict;
                    end
                    default:  state_d = S_DECIDE;
                endcase
            end
            S_PRE: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = LD_RP;
                state_d    = S_WAIT_RP;
            end
            S_WAIT_RP:  state_d = cnt_expire_s ? S_ACT : S_WAIT_RP;
            S_ACT: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = LD_RCD;
                state_d    = S_WAIT_RCD;
            end
            S_WAIT_RCD: state_d = cnt_expire_s ? S_RW : S_WAIT_RCD;
            S_RW: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = LD_CL;
                state_d    = S_WAIT_CL;
            end
            S_WAIT_CL:  state_d = cnt_expire_s ? S_RESOLVE : S_WAIT_CL;
            S_RESOLVE:  state_d = S_IDLE;
            S_REF_CHK:  state_d = ro_all_row_closed ? S_REF_ISSUE : S_REF_PREA;
            S_REF_PREA: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = LD_RP;
                state_d    = S_REF_WAIT_RP;
            end
            S_REF_WAIT_RP: state_d = cnt_expire_s ? S_REF_ISSUE : S_REF_WAIT_RP;
            S_REF_ISSUE: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = LD_RFC;
                state_d    = S_REF_WAIT;
            end
            S_REF_WAIT: state_d = cnt_expire_s ? S_REF_DONE : S_REF_WAIT;
            S_REF_DONE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state.
    always_comb begin
        cmd_d       = state_cmd(state_d, wr_d);
        cmd_valid_d = (cmd_d != CMD_NOP);
        cmd_bg_d    = 2'b00;
        cmd_bank_d  = 2'b00;
        cmd_row_d   = {ROW_BITS{1'b0}};
        cmd_col_d   = {COL_BITS{1'b0}};
        if (state_d == S_PRE || state_d == S_ACT || state_d == S_RW) begin
            cmd_bg_d   = bg_d;
            cmd_bank_d = bank_d;
        end else begin
            cmd_bg_d   = 2'b00;
            cmd_bank_d = 2'b00;
        end
        if (state_d == S_PRE) begin
            cmd_row_d = conf_d;
        end else if (state_d == S_ACT) begin
            cmd_row_d = row_d;
        end else begin
            cmd_row_d = {ROW_BITS{1'b0}};
        end
        if (state_d == S_RW) begin
            cmd_col_d = col_d;
        end else begin
            cmd_col_d = {COL_BITS{1'b0}};
        end
        ro_req_en_d  = (state_d >= S_LOOKUP) && (state_d <= S_RESOLVE);
        ro_refresh_d = (state_d >= S_REF_CHK) && (state_d <= S_REF_WAIT);
        resolve_d    = (state_d == S_RESOLVE);
        ref_ack_d    = (state_d == S_REF_DONE);
    end

    // State, captured request and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            bg_q         <= 2'b00;
            bank_q       <= 2'b00;
            row_q        <= {ROW_BITS{1'b0}};
            col_q        <= {COL_BITS{1'b0}};
            conf_q       <= {ROW_BITS{1'b0}};
            cmd_valid_q  <= 1'b0;
            cmd_q        <= CMD_NOP;
            cmd_bg_q     <= 2'b00;
            cmd_bank_q   <= 2'b00;
            cmd_row_q    <= {ROW_BITS{1'b0}};
            cmd_col_q    <= {COL_BITS{1'b0}};
            ro_req_en_q  <= 1'b0;
            ro_refresh_q <= 1'b0;
            resolve_q    <= 1'b0;
            ref_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            bg_q         <= bg_d;
            bank_q       <= bank_d;
            row_q        <= row_d;
            col_q        <= col_d;
            conf_q       <= conf_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            cmd_bg_q     <= cmd_bg_d;
            cmd_bank_q   <= cmd_bank_d;
            cmd_row_q    <= cmd_row_d;
            cmd_col_q    <= cmd_col_d;
            ro_req_en_q  <= ro_req_en_d;
            ro_refresh_q <= ro_refresh_d;
            resolve_q    <= resolve_d;
            ref_ack_q    <= ref_ack_d;
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd            = cmd_q;
    assign cmd_bg         = cmd_bg_q;
    assign cmd_bank       = cmd_bank_q;
    assign cmd_row        = cmd_row_q;
    assign cmd_col        = cmd_col_q;
    assign ro_req_en      = ro_req_en_q;
    assign ro_refresh     = ro_refresh_q;
    assign ro_row_resolve = resolve_q;
    assign done           = resolve_q;
    assign ref_ack        = ref_ack_q;
    assign ro_bank_group  = bg_q;
    assign ro_bank        = bank_q;
    assign ro_row         = row_q;

`ifdef CMD_PERF_CNT_EN
    logic [15:0] hit_q, miss_q, conf_cnt_q;
    logic        in_decide_s;

    assign in_decide_s = (state_q == S_DECIDE);

    // Saturating row-status counters, bumped once per DECIDE exit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_q      <= 16'h0000;
            miss_q     <= 16'h0000;
            conf_cnt_q <= 16'h0000;
        end else if (in_decide_s) begin
            if (ro_row_stat == ROW_HIT && hit_q != 16'hFFFF) begin
                hit_q <= hit_q + 16'h0001;
            end
            if (ro_row_stat == ROW_MISS && miss_q != 16'hFFFF) begin
                miss_q <= miss_q + 16'h0001;
            end
            if (ro_row_stat == ROW_CONFLICT && conf_cnt_q != 16'hFFFF) begin
                conf_cnt_q <= conf_cnt_q + 16'h0001;
            end
        end
    end

    assign hit_cnt      = hit_q;
    assign miss_cnt     = miss_q;
    assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed testbench for dram_cmd_sequencer: table of request vectors with
// hand-computed command cycles, plus refresh, refresh-vs-request priority
// and mid-sequence reset sequences.
module tb_dram_cmd_sequencer;
    import dram_pkg::*;

    logic                CLK = 1'b0;
    logic                nRST;
    logic                req_valid, req_ready, req_write;
    logic [1:0]          req_bg, req_bank;
    logic [ROW_BITS-1:0] req_row;
    logic [COL_BITS-1:0] req_col;
    logic                ref_req, ref_ack, done;
    logic                ro_req_en, ro_refresh, ro_row_resolve;
    logic [1:0]          ro_bank_group, ro_bank;
    logic [ROW_BITS-1:0] ro_row;
    logic [1:0]          ro_row_stat;
    logic [ROW_BITS-1:0] ro_row_conflict;
    logic                ro_all_row_closed;
    logic                cmd_valid;
    cmd_t                cmd;
    logic [1:0]          cmd_bg, cmd_bank;
    logic [ROW_BITS-1:0] cmd_row;
    logic [COL_BITS-1:0] cmd_col;

    int checks   = 0;
    int failures = 0;

    dram_cmd_sequencer dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .ref_req(ref_req), .ref_ack(ref_ack), .done(done),
        .ro_req_en(ro_req_en), .ro_refresh(ro_refresh), .ro_row_resolve(ro_row_resolve),
        .ro_bank_group(ro_bank_group), .ro_bank(ro_bank), .ro_row(ro_row),
        .ro_row_stat(ro_row_stat), .ro_row_conflict(ro_row_conflict),
        .ro_all_row_closed(ro_all_row_closed),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                wr;
        logic [1:0]          bg;
        logic [1:0]          bank;
        logic [1:0]          stat;
        logic [ROW_BITS-1:0] row;
        logic [ROW_BITS-1:0] conf;
        logic [COL_BITS-1:0] col;
        int                  pre_c;
        int                  act_c;
        int                  rw_c;
        int                  done_c;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One request from acceptance (cycle 0) until done; records command cycles.
    task automatic run_req(input vec_t v, input string tag);
        int   pre_c = -1, act_c = -1, rw_c = -1, done_c = -1, res_c = -1;
        int   ncmd = 0, en_bad = 0, exp_ncmd = 0;
        cmd_t exp_rw;
        exp_rw = v.wr ? CMD_WR : CMD_RD;
        @(negedge CLK);
        req_valid = 1'b1; req_write = v.wr; req_bg = v.bg; req_bank = v.bank;
        req_row = v.row; req_col = v.col;
        ro_row_stat = v.stat; ro_row_conflict = v.conf;
        #1;
        chk({tag, ":req_ready"}, int'(req_ready), 1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            @(negedge CLK);
            if (cmd_valid) begin
                ncmd++;
                if (cmd == CMD_PRE) begin
                    pre_c = c;
                    chk({tag, ":pre_row"}, int'(cmd_row), int'(v.conf));
                end else if (cmd == CMD_ACT) begin
                    act_c = c;
                    chk({tag, ":act_row"}, int'(cmd_row), int'(v.row));
                end else begin
                    rw_c = c;
                    chk({tag, ":rw_cmd"}, int'(cmd), int'(exp_rw));
                    chk({tag, ":rw_col"}, int'(cmd_col), int'(v.col));
                    chk({tag, ":rw_bgbank"}, int'({cmd_bg, cmd_bank}), int'({v.bg, v.bank}));
                end
            end
            if (ro_row_resolve && res_c < 0) res_c = c;
            if (done) done_c = c;
            if (!ro_req_en || ro_row !== v.row || ro_bank !== v.bank ||
                ro_bank_group !== v.bg) en_bad++;
        end
        if (v.pre_c >= 0) exp_ncmd++;
        if (v.act_c >= 0) exp_ncmd++;
        exp_ncmd++;
        chk({tag, ":pre_cycle"}, pre_c, v.pre_c);
        chk({tag, ":act_cycle"}, act_c, v.act_c);
        chk({tag, ":rw_cycle"}, rw_c, v.rw_c);
        chk({tag, ":done_cycle"}, done_c, v.done_c);
        chk({tag, ":resolve_cycle"}, res_c, v.done_c);
        chk({tag, ":cmd_count"}, ncmd, exp_ncmd);
        chk({tag, ":lookup_hold_bad"}, en_bad, 0);
        @(negedge CLK);
        chk({tag, ":idle_after"}, int'({done, ro_req_en, cmd_valid}), 0);
    endtask

    // Refresh from IDLE (cycle 0); optionally with a competing request.
    task automatic run_ref(input logic closed, input logic with_req,
                           input int exp_prea, input int exp_ref,
                           input int exp_ack, input string tag);
        int prea_c = -1, ref_c = -1, ack_c = -1, bad_cmd = 0, rf_bad = 0, rdy_bad = 0;
        @(negedge CLK);
        ref_req = 1'b1; ro_all_row_closed = closed;
        req_valid = with_req; req_write = vecs[0].wr; req_bg = vecs[0].bg;
        req_bank = vecs[0].bank; req_row = vecs[0].row; req_col = vecs[0].col;
        #1;
        chk({tag, ":ready_c0"}, int'(req_ready), 0);
        for (int c = 1; c <= 40 && ack_c < 0; c++) begin
            @(negedge CLK);
            if (cmd_valid) begin
                if (cmd == CMD_PREA) prea_c = c;
                else if (cmd == CMD_REF) ref_c = c;
                else bad_cmd++;
            end
            if (req_ready) rdy_bad++;
            if (ref_ack) begin
                ack_c = c;
                chk({tag, ":refresh_at_ack"}, int'(ro_refresh), 0);
                ref_req = 1'b0;
            end else if (!ro_refresh) begin
                rf_bad++;
            end
        end
        chk({tag, ":prea_cycle"}, prea_c, exp_prea);
        chk({tag, ":ref_cycle"}, ref_c, exp_ref);
        chk({tag, ":ack_cycle"}, ack_c, exp_ack);
        chk({tag, ":other_cmds"}, bad_cmd, 0);
        chk({tag, ":refresh_hold_bad"}, rf_bad, 0);
        chk({tag, ":ready_during_ref"}, rdy_bad, 0);
    endtask

    initial begin
        vecs[0] = '{wr: 1'b0, bg: 2'd1, bank: 2'd2, stat: ROW_HIT, row: 16'h001A,
                    conf: 16'h0000, col: 10'h040, pre_c: -1, act_c: -1, rw_c: 3, done_c: 7};
        vecs[1] = '{wr: 1'b1, bg: 2'd2, bank: 2'd1, stat: ROW_MISS, row: 16'h0123,
                    conf: 16'h0000, col: 10'h3FF, pre_c: -1, act_c: 3, rw_c: 7, done_c: 11};
        vecs[2] = '{wr: 1'b0, bg: 2'd0, bank: 2'd3, stat: ROW_CONFLICT, row: 16'h0009,
                    conf: 16'h0005, col: 10'h011, pre_c: 3, act_c: 7, rw_c: 11, done_c: 15};
        vecs[3] = '{wr: 1'b1, bg: 2'd3, bank: 2'd3, stat: ROW_HIT, row: 16'hFFFF,
                    conf: 16'h0000, col: 10'h000, pre_c: -1, act_c: -1, rw_c: 3, done_c: 7};

        nRST = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_bg = 2'd0; req_bank = 2'd0;
        req_row = '0; req_col = '0; ref_req = 1'b0; ro_row_stat = ROW_IDLE;
        ro_row_conflict = '0; ro_all_row_closed = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_ctrl", int'({cmd_valid, done, ro_req_en, ro_refresh, ref_ack, req_ready}), 0);
        chk("reset_cmd", int'(cmd), int'(CMD_NOP));
        chk("reset_row", int'(ro_row), 0);
        nRST = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end

        run_ref(1'b0, 1'b0, 2, 6, 22, "ref_open");
        run_ref(1'b1, 1'b0, -1, 2, 18, "ref_closed");
        run_ref(1'b1, 1'b1, -1, 2, 18, "ref_vs_req");
        run_req(vecs[0], "after_ref");

        // Reset during WAIT_RCD of a miss request.
        @(negedge CLK);
        req_valid = 1'b1; req_write = vecs[1].wr; req_bg = vecs[1].bg;
        req_bank = vecs[1].bank; req_row = vecs[1].row; req_col = vecs[1].col;
        ro_row_stat = ROW_MISS;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("rst_mid_ctrl", int'({cmd_valid, done, ro_row_resolve, ro_req_en, ro_refresh, ref_ack}), 0);
        chk("rst_mid_cmd", int'(cmd), int'(CMD_NOP));
        chk("rst_mid_addr", int'({ro_row, ro_bank, ro_bank_group}), 0);
        repeat (2) @(negedge CLK);
        chk("rst_hold_resolve", int'({done, ro_row_resolve}), 0);
        nRST = 1'b1;
        run_req(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
